// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths and branch condition encodings,
// plus the condition evaluator used by the operand-fetch stage.
package proc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_Z  = 3'b001,
    COND_NZ = 3'b010,
    COND_S  = 3'b011,
    COND_NS = 3'b100,
    COND_C  = 3'b101,
    COND_O  = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  function automatic logic cond_eval(input logic [2:0] cond,
                                     input logic o, input logic s,
                                     input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = z;
      COND_NZ: taken = ~z;
      COND_S:  taken = s;
      COND_NS: taken = ~s;
      COND_C:  taken = c;
      COND_O:  taken = o;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of decode, writeback, flag and execute-side signals around operand fetch.
// The master side drives the stage inputs; the slave side is the stage itself.
interface operand_fetch_if #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W
);
  logic              uc_VALID;
  logic [ADDR_W-1:0] uc_RA;
  logic [ADDR_W-1:0] uc_RB;
  logic [ADDR_W-1:0] uc_WD;
  logic              uc_WE;
  logic [2:0]        uc_COND;
  logic [ADDR_W-1:0] wb_WA;
  logic              wb_WE;
  logic [DATA_W-1:0] mxrb_out;
  logic              rf_O;
  logic              rf_S;
  logic              rf_C;
  logic              rf_Z;
  logic              ex_HOLD;
  logic              of_FLUSH;
  logic              of_STALL;
  logic              of_VALID;
  logic [DATA_W-1:0] of_A;
  logic [DATA_W-1:0] of_B;
  logic [ADDR_W-1:0] of_WD;
  logic              of_WE;
  logic              of_TAKEN;

  modport master (
    output uc_VALID, uc_RA, uc_RB, uc_WD, uc_WE, uc_COND,
    output wb_WA, wb_WE, mxrb_out, rf_O, rf_S, rf_C, rf_Z,
    output ex_HOLD, of_FLUSH,
    input  of_STALL, of_VALID, of_A, of_B, of_WD, of_WE, of_TAKEN
  );

  modport slave (
    input  uc_VALID, uc_RA, uc_RB, uc_WD, uc_WE, uc_COND,
    input  wb_WA, wb_WE, mxrb_out, rf_O, rf_S, rf_C, rf_Z,
    input  ex_HOLD, of_FLUSH,
    output of_STALL, of_VALID, of_A, of_B, of_WD, of_WE, of_TAKEN
  );
endinterface

// File: rtl/reg_bank.sv
// 2-read/1-write register bank; a same-cycle write is forwarded to the read ports.
// Entries are flops because the whole bank must clear on reset.
module reg_bank #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        entry_reg <= '0;
      end else if (we && (wa == ADDR_W'(gi))) begin
        entry_reg <= wd;
      end
    end

    assign mem_q[gi] = entry_reg;
  end

  assign rd_a = (we && (wa == ra)) ? wd : mem_q[ra];
  assign rd_b = (we && (wa == rb)) ? wd : mem_q[rb];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: bypassed register read, RAW scoreboard with stall,
// branch condition evaluation and the pipeline register feeding execute.
module operand_fetch #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  operand_fetch_if.slave bus
);
  import proc_pkg::cond_eval;

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [NREGS-1:0]  pending_reg;
  logic [NREGS-1:0]  pending_next;
  logic              haz_a;
  logic              haz_b;
  logic              stall;
  logic              issue;
  logic              taken;

  logic              valid_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [ADDR_W-1:0] wd_reg;
  logic              we_reg;
  logic              taken_reg;

  reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_reg_bank (
    .CLK  (CLK),
    .RST_N(RST_N),
    .we   (bus.wb_WE),
    .wa   (bus.wb_WA),
    .wd   (bus.mxrb_out),
    .ra   (bus.uc_RA),
    .rb   (bus.uc_RB),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );

  // A pending source is not a hazard when its writeback lands this cycle.
  assign haz_a = pending_reg[bus.uc_RA] && !(bus.wb_WE && (bus.wb_WA == bus.uc_RA));
  assign haz_b = pending_reg[bus.uc_RB] && !(bus.wb_WE && (bus.wb_WA == bus.uc_RB));
  assign stall = bus.uc_VALID && (haz_a || haz_b);
  assign issue = bus.uc_VALID && !stall && !bus.ex_HOLD && !bus.of_FLUSH;
  assign taken = cond_eval(bus.uc_COND, bus.rf_O, bus.rf_S, bus.rf_C, bus.rf_Z);

  // Clears are applied first so that a same-cycle set of the same bit wins.
  always_comb begin
    pending_next = pending_reg;
    if (bus.of_FLUSH && valid_reg && we_reg) begin
      pending_next[wd_reg] = 1'b0;
    end
    if (bus.wb_WE) begin
      pending_next[bus.wb_WA] = 1'b0;
    end
    if (issue && bus.uc_WE) begin
      pending_next[bus.uc_WD] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      wd_reg    <= '0;
      we_reg    <= 1'b0;
      taken_reg <= 1'b0;
    end else if (bus.of_FLUSH) begin
      valid_reg <= 1'b0;
    end else if (!bus.ex_HOLD) begin
      valid_reg <= issue;
      if (issue) begin
        a_reg     <= rd_a;
        b_reg     <= rd_b;
        wd_reg    <= bus.uc_WD;
        we_reg    <= bus.uc_WE;
        taken_reg <= taken;
      end
    end
  end

  assign bus.of_STALL = stall;
  assign bus.of_VALID = valid_reg;
  assign bus.of_A     = a_reg;
  assign bus.of_B     = b_reg;
  assign bus.of_WD    = wd_reg;
  assign bus.of_WE    = we_reg;
  assign bus.of_TAKEN = taken_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed corner sequences, a condition-code table and
// randomized traffic checked against a cycle-level model of the stage's rules.
module tb_operand_fetch;
  import proc_pkg::*;

  logic CLK;
  logic RST_N;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  operand_fetch_if bus ();

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] cond;
    logic       exp_taken;
  } cond_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_regs [16];
  logic        m_pend [16];
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [3:0]  m_wd;
  logic        m_we;
  logic        m_taken;
  logic        s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] cond, input logic o, input logic s,
                                     input logic c, input logic z);
    logic [7:0] table_bits;
    table_bits = {1'b0, o, c, ~s, s, ~z, z, 1'b1};
    return table_bits[cond];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_valid = 0; m_a = '0; m_b = '0; m_wd = '0; m_we = 0; m_taken = 0;
  endtask

  task automatic idle();
    bus.uc_VALID = 0; bus.uc_RA = '0; bus.uc_RB = '0; bus.uc_WD = '0; bus.uc_WE = 0;
    bus.uc_COND = 3'b000; bus.wb_WA = '0; bus.wb_WE = 0; bus.mxrb_out = '0;
    bus.rf_O = 0; bus.rf_S = 0; bus.rf_C = 0; bus.rf_Z = 0;
    bus.ex_HOLD = 0; bus.of_FLUSH = 0;
  endtask

  // One clock: check stall before the edge, advance the model, check the register after.
  task automatic cycle(input string tag);
    logic e_stall, e_issue, e_taken, fl, hd, wbe, uwe;
    logic [31:0] e_a, e_b, wdat;
    logic [3:0] wa, uwd;
    #1;
    e_stall = bus.uc_VALID &&
              ((m_pend[bus.uc_RA] && !(bus.wb_WE && bus.wb_WA == bus.uc_RA)) ||
               (m_pend[bus.uc_RB] && !(bus.wb_WE && bus.wb_WA == bus.uc_RB)));
    s_stall = bus.of_STALL;
    chk({tag, ".stall"}, 32'(s_stall), 32'(e_stall));
    e_issue = bus.uc_VALID && !e_stall && !bus.ex_HOLD && !bus.of_FLUSH;
    e_a = (bus.wb_WE && bus.wb_WA == bus.uc_RA) ? bus.mxrb_out : m_regs[bus.uc_RA];
    e_b = (bus.wb_WE && bus.wb_WA == bus.uc_RB) ? bus.mxrb_out : m_regs[bus.uc_RB];
    e_taken = ref_taken(bus.uc_COND, bus.rf_O, bus.rf_S, bus.rf_C, bus.rf_Z);
    fl = bus.of_FLUSH; hd = bus.ex_HOLD; wbe = bus.wb_WE; wa = bus.wb_WA;
    wdat = bus.mxrb_out; uwe = bus.uc_WE; uwd = bus.uc_WD;
    @(posedge CLK);
    if (fl) begin
      if (m_valid && m_we) m_pend[m_wd] = 1'b0;
      m_valid = 1'b0;
    end else if (!hd) begin
      m_valid = e_issue;
      if (e_issue) begin
        m_a = e_a; m_b = e_b; m_wd = uwd; m_we = uwe; m_taken = e_taken;
      end
    end
    if (wbe) begin
      m_regs[wa] = wdat;
      m_pend[wa] = 1'b0;
    end
    if (e_issue && uwe) m_pend[uwd] = 1'b1;
    #1;
    chk({tag, ".valid"}, 32'(bus.of_VALID), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".A"}, bus.of_A, m_a);
      chk({tag, ".B"}, bus.of_B, m_b);
      chk({tag, ".WD"}, 32'(bus.of_WD), 32'(m_wd));
      chk({tag, ".WE"}, 32'(bus.of_WE), 32'(m_we));
      chk({tag, ".TAKEN"}, 32'(bus.of_TAKEN), 32'(m_taken));
    end
    $display("[%0t] %s stall=%b valid=%b A=%08h B=%08h WD=%0d WE=%b T=%b", $time, tag,
             s_stall, bus.of_VALID, bus.of_A, bus.of_B, bus.of_WD, bus.of_WE, bus.of_TAKEN);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.of_VALID), 32'd0);
    chk({tag, ".A"}, bus.of_A, 32'd0);
    chk({tag, ".B"}, bus.of_B, 32'd0);
    chk({tag, ".WD"}, 32'(bus.of_WD), 32'd0);
    chk({tag, ".WE"}, 32'(bus.of_WE), 32'd0);
    chk({tag, ".TAKEN"}, 32'(bus.of_TAKEN), 32'd0);
    chk({tag, ".stall"}, 32'(bus.of_STALL), 32'd0);
  endtask

  initial begin
    cond_vec_t cvec[8];
    cvec[0] = '{3'b000, 1'b1}; cvec[1] = '{3'b001, 1'b1};
    cvec[2] = '{3'b010, 1'b0}; cvec[3] = '{3'b011, 1'b0};
    cvec[4] = '{3'b100, 1'b1}; cvec[5] = '{3'b101, 1'b1};
    cvec[6] = '{3'b110, 1'b0}; cvec[7] = '{3'b111, 1'b0};

    // Power-on reset
    RST_N = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("por");
    RST_N = 1'b1;

    // Reset mid-operation: r3 written and pending, live instruction in the register
    idle(); bus.wb_WE = 1; bus.wb_WA = 4'd3; bus.mxrb_out = 32'h1234_5678;
    cycle("rst_wr");
    idle(); bus.uc_VALID = 1; bus.uc_WD = 4'd3; bus.uc_WE = 1; bus.uc_COND = 3'b000;
    cycle("rst_iss");
    idle(); bus.uc_VALID = 1; bus.uc_RA = 4'd3;
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cycle("rst_rd");
    chk("rst_rd.stall0", 32'(s_stall), 32'd0);
    chk("rst_rd.A0", bus.of_A, 32'd0);

    // Same-cycle writeback bypass
    idle(); bus.wb_WE = 1; bus.wb_WA = 4'd5; bus.mxrb_out = 32'hDEAD_BEEF;
    bus.uc_VALID = 1; bus.uc_RA = 4'd5; bus.uc_RB = 4'd5;
    cycle("byp");
    chk("byp.stall0", 32'(s_stall), 32'd0);
    chk("byp.A", bus.of_A, 32'hDEAD_BEEF);

    // RAW stall on r2 until its writeback arrives
    idle(); bus.uc_VALID = 1; bus.uc_WD = 4'd2; bus.uc_WE = 1;
    cycle("raw_prod");
    for (int i = 0; i < 2; i++) begin
      idle(); bus.uc_VALID = 1; bus.uc_RB = 4'd2;
      cycle("raw_wait");
      chk("raw_wait.stall1", 32'(s_stall), 32'd1);
      chk("raw_wait.valid0", 32'(bus.of_VALID), 32'd0);
    end
    idle(); bus.uc_VALID = 1; bus.uc_RB = 4'd2;
    bus.wb_WE = 1; bus.wb_WA = 4'd2; bus.mxrb_out = 32'hCAFE_0002;
    cycle("raw_go");
    chk("raw_go.stall0", 32'(s_stall), 32'd0);
    chk("raw_go.valid1", 32'(bus.of_VALID), 32'd1);
    chk("raw_go.B", bus.of_B, 32'hCAFE_0002);

    // Set/clear collision on r7: set wins
    idle(); bus.wb_WE = 1; bus.wb_WA = 4'd7; bus.mxrb_out = 32'h7777_0007;
    bus.uc_VALID = 1; bus.uc_WD = 4'd7; bus.uc_WE = 1;
    cycle("coll");
    idle(); bus.uc_VALID = 1; bus.uc_RA = 4'd7;
    cycle("coll_rd");
    chk("coll_rd.stall1", 32'(s_stall), 32'd1);
    idle(); bus.wb_WE = 1; bus.wb_WA = 4'd7; bus.mxrb_out = 32'h0000_0077;
    cycle("coll_clr");

    // Flush under hold releases the killed destination r4
    idle(); bus.uc_VALID = 1; bus.uc_WD = 4'd4; bus.uc_WE = 1;
    cycle("fl_iss");
    chk("fl_iss.WD", 32'(bus.of_WD), 32'd4);
    idle(); bus.ex_HOLD = 1; bus.of_FLUSH = 1;
    cycle("fl_kill");
    chk("fl_kill.valid0", 32'(bus.of_VALID), 32'd0);
    idle(); bus.uc_VALID = 1; bus.uc_RA = 4'd4;
    cycle("fl_rd");
    chk("fl_rd.stall0", 32'(s_stall), 32'd0);

    // Condition-code table with Z=1 S=0 C=1 O=0
    for (int i = 0; i < 8; i++) begin
      idle(); bus.uc_VALID = 1; bus.uc_COND = cvec[i].cond;
      bus.rf_Z = 1; bus.rf_S = 0; bus.rf_C = 1; bus.rf_O = 0;
      cycle("cond");
      chk($sformatf("cond%0d.TAKEN", i), 32'(bus.of_TAKEN), 32'(cvec[i].exp_taken));
    end

    // Randomized traffic concentrated on a few registers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.uc_VALID = ($urandom_range(0, 3) != 0);
      bus.uc_RA    = 4'($urandom_range(0, 3));
      bus.uc_RB    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      bus.uc_WD    = 4'($urandom_range(0, 3));
      bus.uc_WE    = 1'($urandom_range(0, 1));
      bus.uc_COND  = 3'($urandom_range(0, 7));
      bus.wb_WE    = ($urandom_range(0, 2) != 0);
      bus.wb_WA    = 4'($urandom_range(0, 3));
      bus.mxrb_out = $urandom;
      bus.rf_O     = 1'($urandom_range(0, 1));
      bus.rf_S     = 1'($urandom_range(0, 1));
      bus.rf_C     = 1'($urandom_range(0, 1));
      bus.rf_Z     = 1'($urandom_range(0, 1));
      bus.ex_HOLD  = ($urandom_range(0, 4) == 0);
      bus.of_FLUSH = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
